// File: rtl/data_xform_if.sv
// -----------------------------------------------------------------------------
// data_xform_if
// Handshake and status bundle for data_xform_unit.
//   ctrl/in_data/in_valid/in_ready : operand input stream (ctrl picks the op)
//   out_data/out_op/out_valid/out_ready : result stream from the FIFO head
//   clr_flags : one-cycle pulse that clears the sticky ovf/ill flags
//   level     : FIFO occupancy, 0..DEPTH
//   status    : packed status word
// Modports: slave = the transform unit, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface data_xform_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic [2:0]              ctrl;
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       out_data;
  logic [2:0]              out_op;
  logic                    out_valid;
  logic                    out_ready;
  logic                    clr_flags;
  logic [$clog2(DEPTH):0]  level;
  logic [7:0]              status;

  modport slave (
    input  ctrl, in_data, in_valid, out_ready, clr_flags,
    output in_ready, out_data, out_op, out_valid, level, status
  );

  modport master (
    output ctrl, in_data, in_valid, out_ready, clr_flags,
    input  in_ready, out_data, out_op, out_valid, level, status
  );
endinterface

// File: rtl/data_xform_unit.sv
// -----------------------------------------------------------------------------
// data_xform_unit
// Applies a per-word operation chosen by ctrl to each accepted operand and
// queues {ctrl, result} in a small FIFO. Sticky ovf/ill flags and an en flag
// are reported through the status word.
//   clk : clock
//   rst : asynchronous, active-high reset (flushes FIFO, clears flags)
//   bus : data_xform_if.slave (operand stream, result stream, flags, status)
// Ops: 001 dec by DEC_STEP, 010 inc by INC_STEP, 011 invert, 100 pass,
//      000 zero, 101..111 zero + illegal flag.
// Build option: define DATA_XFORM_SATURATE_EN to clamp dec/inc results on
// borrow/carry instead of wrapping; ovf is flagged in both builds.
// status = {0, empty, en, ill, ovf, full, 0, out_valid}; 8'h02 while rst.
// -----------------------------------------------------------------------------
module data_xform_unit #(
  parameter int DATA_W   = 8,
  parameter int DEC_STEP = 1,
  parameter int INC_STEP = 2,
  parameter int DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst,
  data_xform_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_W + 1;
  localparam int MW = DATA_W + 3;

  logic [MW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              en_reg, ovf_reg, ill_reg;

  logic              full, empty, push, pop, in_ready_int;
  logic [EW-1:0]     diff_ext, sum_ext;
  logic              borrow, carry;
  logic [DATA_W-1:0] result_next;
  logic              en_next, ovf_hit, ill_hit;
  logic [MW-1:0]     head;

  assign full         = (level_reg == LW'(DEPTH));
  assign empty        = (level_reg == '0);
  // rst feeds in_ready directly so nothing is accepted while held in reset
  assign in_ready_int = !rst && !full;
  assign push         = bus.in_valid && in_ready_int;
  assign pop          = !empty && bus.out_ready;

  // One extra bit exposes the borrow/carry out of the dec/inc paths
  assign diff_ext = {1'b0, bus.in_data} - EW'(DEC_STEP);
  assign sum_ext  = {1'b0, bus.in_data} + EW'(INC_STEP);
  assign borrow   = diff_ext[DATA_W];
  assign carry    = sum_ext[DATA_W];

  always_comb begin
    result_next = '0;
    en_next     = en_reg;
    ovf_hit     = 1'b0;
    ill_hit     = 1'b0;
    case (bus.ctrl)
      3'b001: begin
        ovf_hit = borrow;
        en_next = 1'b1;
`ifdef DATA_XFORM_SATURATE_EN
        result_next = borrow ? '0 : diff_ext[DATA_W-1:0];
`else
        result_next = diff_ext[DATA_W-1:0];
`endif
      end
      3'b010: begin
        ovf_hit = carry;
        en_next = 1'b1;
`ifdef DATA_XFORM_SATURATE_EN
        result_next = carry ? '1 : sum_ext[DATA_W-1:0];
`else
        result_next = sum_ext[DATA_W-1:0];
`endif
      end
      3'b011: begin
        result_next = ~bus.in_data;
        en_next     = 1'b0;
      end
      3'b100: result_next = bus.in_data;
      3'b000: en_next = 1'b0;
      default: begin
        ill_hit = 1'b1;
        en_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      en_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
      ill_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (push) en_reg <= en_next;
      // A set in the same cycle as clr_flags takes priority
      ovf_reg <= (push && ovf_hit) || (ovf_reg && !bus.clr_flags);
      ill_reg <= (push && ill_hit) || (ill_reg && !bus.clr_flags);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/level
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {bus.ctrl, result_next};
  end

  assign head          = mem[rd_ptr_reg];
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : head[DATA_W-1:0];
  assign bus.out_op    = empty ? '0 : head[MW-1:DATA_W];
  assign bus.level     = level_reg;
  assign bus.status    = rst ? 8'h02
                             : {1'b0, empty, en_reg, ill_reg, ovf_reg, full, 1'b0, !empty};
endmodule

// File: tb/tb_data_xform_unit.sv
module tb_data_xform_unit;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_xform_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  data_xform_unit #(.DATA_W(DATA_W), .DEC_STEP(1), .INC_STEP(2), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of {op, result}, plus flag bits
  logic [10:0] q[$];
  bit m_en, m_ovf, m_ill;

`ifdef DATA_XFORM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic on plain integers straight from the op table
  task automatic ref_op(input logic [2:0] c, input logic [7:0] d, input bit en_old,
                        output logic [7:0] r, output bit ovf, output bit ill, output bit en);
    int v;
    ovf = 0; ill = 0; en = en_old; r = 8'h00;
    case (c)
      3'd1: begin
        v = int'(d) - 1; en = 1;
        if (v < 0) begin ovf = 1; r = SAT ? 8'h00 : 8'(v + 256); end
        else r = 8'(v);
      end
      3'd2: begin
        v = int'(d) + 2; en = 1;
        if (v > 255) begin ovf = 1; r = SAT ? 8'hFF : 8'(v - 256); end
        else r = 8'(v);
      end
      3'd3: begin r = 8'(255 - int'(d)); en = 0; end
      3'd4: r = d;
      3'd0: en = 0;
      default: begin ill = 1; en = 0; end
    endcase
  endtask

  task automatic check_all();
    logic [7:0] exp_status;
    bit e, f;
    e = (q.size() == 0);
    f = (q.size() == DEPTH);
    exp_status = {1'b0, e, m_en, m_ill, m_ovf, f, 1'b0, !e};
    check("level", 32'(bus.level), 32'(q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(!e));
    check("in_ready", 32'(bus.in_ready), 32'(!f));
    check("status", 32'(bus.status), 32'(exp_status));
    if (!e) begin
      check("out_data", 32'(bus.out_data), 32'(q[0][7:0]));
      check("out_op", 32'(bus.out_op), 32'(q[0][10:8]));
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at posedge+1 after checking
  task automatic step(input bit v, input logic [2:0] c, input logic [7:0] d,
                      input bit ordy, input bit clr);
    logic [7:0] r;
    bit o, i, en, acc, popq;
    bus.in_valid = v; bus.ctrl = c; bus.in_data = d;
    bus.out_ready = ordy; bus.clr_flags = clr;
    acc  = v && (q.size() < DEPTH);
    popq = ordy && (q.size() > 0);
    ref_op(c, d, m_en, r, o, i, en);
    @(posedge clk); #1;
    if (popq) void'(q.pop_front());
    if (acc) begin q.push_back({c, r}); m_en = en; end
    m_ovf = (acc && o) || (m_ovf && !clr);
    m_ill = (acc && i) || (m_ill && !clr);
    $display("[TB] t=%0t v=%0d ctrl=%0d d=%02h ordy=%0d clr=%0d -> level=%0d out=%02h status=%02h",
             $time, v, c, d, ordy, clr, bus.level, bus.out_data, bus.status);
    check_all();
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.ctrl = 0; bus.in_data = 0; bus.out_ready = 0; bus.clr_flags = 0;
  endtask

  logic [7:0] drain_exp [4];

  initial begin
    idle();
    #1;
    // Reset state while rst is held
    check("rst_status", 32'(bus.status), 32'h02);
    check("rst_level", 32'(bus.level), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("post_rst_status", 32'(bus.status), 32'h40);
    check_all();

    // Increment, one-cycle latency, then consumed
    step(1, 3'b010, 8'h10, 1, 0);
    check("inc_data", 32'(bus.out_data), 32'h12);
    check("inc_op", 32'(bus.out_op), 32'h2);
    check("inc_en", 32'(bus.status[5]), 32'h1);
    step(0, 3'b000, 8'h00, 1, 0);
    check("inc_popped", 32'(bus.out_valid), 32'h0);

    // Carry and borrow boundaries
    step(1, 3'b010, 8'hFF, 0, 0);
    check("carry_data", 32'(bus.out_data), SAT ? 32'hFF : 32'h01);
    check("carry_ovf", 32'(bus.status[3]), 32'h1);
    step(1, 3'b001, 8'h00, 1, 0);
    check("borrow_data", 32'(bus.out_data), SAT ? 32'h00 : 32'hFF);
    step(0, 3'b000, 8'h00, 1, 1);
    check("ovf_cleared", 32'(bus.status[3]), 32'h0);

    // Fill to full, fifth word blocked, then ordered drain
    step(1, 3'b011, 8'h0F, 0, 0);
    step(1, 3'b011, 8'hF0, 0, 0);
    step(1, 3'b011, 8'hAA, 0, 0);
    step(1, 3'b011, 8'h55, 0, 0);
    step(1, 3'b011, 8'h01, 0, 0);
    check("full_in_ready", 32'(bus.in_ready), 32'h0);
    check("full_level", 32'(bus.level), 32'h4);
    check("full_status2", 32'(bus.status[2]), 32'h1);
    drain_exp[0] = 8'hF0; drain_exp[1] = 8'h0F; drain_exp[2] = 8'h55; drain_exp[3] = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), 32'(bus.out_data), 32'(drain_exp[k]));
      step(0, 3'b000, 8'h00, 1, 0);
    end
    check("drained", 32'(bus.out_valid), 32'h0);

    // Illegal op and sticky flag priority
    step(1, 3'b110, 8'h77, 0, 0);
    check("ill_data", 32'(bus.out_data), 32'h00);
    check("ill_flag", 32'(bus.status[4]), 32'h1);
    check("ill_en", 32'(bus.status[5]), 32'h0);
    step(0, 3'b000, 8'h00, 1, 1);
    check("ill_cleared", 32'(bus.status[4]), 32'h0);
    step(1, 3'b111, 8'h12, 1, 1);
    check("ill_set_wins", 32'(bus.status[4]), 32'h1);
    step(0, 3'b000, 8'h00, 1, 1);

    // Simultaneous push and pop at level 2
    step(1, 3'b100, 8'h11, 0, 0);
    step(1, 3'b100, 8'h22, 0, 0);
    check("pp_level_before", 32'(bus.level), 32'h2);
    step(1, 3'b100, 8'h3C, 1, 0);
    check("pp_level_after", 32'(bus.level), 32'h2);
    check("pp_head", 32'(bus.out_data), 32'h22);
    step(0, 3'b000, 8'h00, 1, 0);
    check("pp_tail", 32'(bus.out_data), 32'h3C);
    step(0, 3'b000, 8'h00, 1, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           bit'($urandom_range(0, 2) != 0), $urandom_range(0, 7) == 0);
    end

    // Mid-stream reset with three words buffered
    for (int n = 0; n < 8 && q.size() > 0; n++) step(0, 3'b000, 8'h00, 1, 0);
    step(1, 3'b100, 8'hA1, 0, 0);
    step(1, 3'b010, 8'hFF, 0, 0);
    step(1, 3'b110, 8'hA3, 0, 0);
    check("pre_rst_level", 32'(bus.level), 32'h3);
    idle();
    #2 rst = 1;
    #1;
    check("midrst_status", 32'(bus.status), 32'h02);
    check("midrst_level", 32'(bus.level), 32'h0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    check("midrst_out_data", 32'(bus.out_data), 32'h0);
    check("midrst_out_op", 32'(bus.out_op), 32'h0);
    q.delete(); m_en = 0; m_ovf = 0; m_ill = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("rel_status", 32'(bus.status), 32'h40);
    check("rel_in_ready", 32'(bus.in_ready), 32'h1);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
